fsm_ds_sink: RTL
================

Name: fsm_ds_sink

Overview:
- Downstream stage of the data-sequencing FSM. Consumes its per-cycle data_out bus and its one-cycle done strobe.
- On each done strobe, captures the result byte into a small first-word-fall-through FIFO and drains it to the next stage over a valid/ready interface.
- Keeps saturating accepted and dropped counters.
- Runs a monitor FSM that raises a sticky error flag when the upstream FSM sits in its error state (bus holding 8'hEE) for too long.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ERR_CYCLES, 3, consecutive 8'hEE cycles (done low) needed to raise err_flag; at least 1
CNT_W, 8, width of acc_cnt and drop_cnt

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
done_in  input  1  upstream done strobe
data_in  input  8  upstream data_out bus
m_valid  output  1  FIFO head valid
m_ready  input  1  downstream accepts head
m_data  output  8  FIFO head byte
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
acc_cnt  output  CNT_W  results accepted into the FIFO, saturating
drop_cnt  output  CNT_W  results dropped because the FIFO was full, saturating
err_clr  input  1  clears err_flag
err_flag  output  1  sticky upstream-error indication

Behaviour:
- Reset: clk is the single clock. rst is asynchronous and active-high. While rst is asserted:
  - FIFO pointers and occupancy are 0, so empty=1, full=0, m_valid=0.
  - m_data=8'h00.
  - acc_cnt=0, drop_cnt=0.
  - err_flag=0; monitor FSM in MON_IDLE with run counter 0.
- Reset mid-operation discards all FIFO contents and counts. There is no flush port.
- Push: push occurs when done_in=1 and (full=0 or pop this cycle).
  - The byte written is data_in sampled on that edge.
  - acc_cnt increments, holding at all-ones.
- Drop: done_in=1 with full=1 and no pop in the same cycle.
  - The byte is discarded; FIFO contents are unchanged.
  - drop_cnt increments, holding at all-ones.
- Pop: pop occurs when m_valid=1 and m_ready=1; rd_ptr advances.
- Read-side outputs:
  - m_valid = !empty.
  - m_data = entry at rd_ptr, combinational from storage; 8'h00 when empty.
  - m_data is stable while m_valid=1 and m_ready=0.
- Latency: done_in on edge N gives m_valid=1 and m_data = that byte after edge N, i.e. first cycle N+1.
- Simultaneous push and pop:
  - Occupancy unchanged. Legal when full (the popped slot is reused).
  - Not possible when empty, since m_valid=0 means no pop.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - full when the MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
- Monitor FSM, updated every edge:
  - MON_IDLE: if data_in==8'hEE and done_in==0, run counter = 1 and go to MON_SUSPECT. If ERR_CYCLES==1, go directly to MON_ERR instead.
  - MON_SUSPECT:
    - If the condition holds, increment the run counter.
    - When the incremented value reaches ERR_CYCLES, go to MON_ERR and set err_flag=1 at that same edge.
    - If the condition breaks, run counter = 0 and go to MON_IDLE.
  - MON_ERR: err_flag=1 and held regardless of data_in; leaves only on err_clr.
  - err_clr=1 in any state: next state MON_IDLE, run counter 0, err_flag=0.
    - The EE condition on the err_clr cycle is ignored.
    - Counting restarts on the following cycle.
    - err_clr has priority over entering MON_ERR on the same edge.
- Push/pop operation is independent of the monitor FSM. Results continue to be captured while err_flag=1.
- done_in=1 with data_in==8'hEE is a valid result: it is pushed and the run counter resets to 0.

Test Plan:
- Reset, then done_in pulses with data_in 8'h11, 8'h22, 8'h33, m_ready=0 → m_valid=1 from cycle after first pulse; m_data=8'h11 held; acc_cnt=3; empty=0, full=0.
- Six done pulses (8'hA0..8'hA5), m_ready=0, DEPTH=4 → full=1 after 4th; acc_cnt=4, drop_cnt=2; then m_ready=1 drains A0, A1, A2, A3 in order; empty=1 afterward.
- Full FIFO, done_in=1 with data 8'h5A while m_ready=1 in the same cycle → A0 popped, 8'h5A accepted, full stays 1, drop_cnt unchanged, acc_cnt+1; drain order ends with 8'h5A.
- data_in=8'hEE, done_in=0 for 2 cycles, then 8'h00 → err_flag stays 0. Then 8'hEE for 3 cycles → err_flag=1 after 3rd edge, stays 1 when data_in returns to 8'h00. Pulse err_clr → err_flag=0 next cycle.
- Push 8'h77 for three consecutive cycles, assert rst asynchronously mid-cycle → m_valid, err_flag, acc_cnt go 0 immediately without a clock edge; after release the first pop returns only newly pushed data.
- Force acc_cnt to 8'hFF by 255 accepted pushes with continuous pop, push once more → acc_cnt stays 8'hFF; the byte is still delivered on m_data.

Source files
------------

// File: rtl/fsm_ds_sink.sv
// fsm_ds_sink: downstream sink for the data-sequencing FSM.
// Captures each done-strobed result byte into a first-word-fall-through FIFO,
// drains it over valid/ready, keeps saturating accept/drop counters and
// watches for the upstream FSM lingering in its error state (bus = 8'hEE).
//
// Handshake: a transfer happens on a rising edge where m_valid=1 and
// m_ready=1; m_valid never depends on m_ready, and m_data holds steady while
// m_valid=1 and m_ready=0.
module fsm_ds_sink #(
    parameter int DEPTH      = 4,
    parameter int ERR_CYCLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done_in,
    input  logic [7:0]       data_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    input  logic             err_clr,
    output logic             err_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(ERR_CYCLES + 1);
    localparam logic [RW-1:0] ERR_MAX = RW'(ERR_CYCLES);
    localparam logic [7:0]    ERR_BYTE = 8'hEE;

    typedef enum logic [1:0] {
        MON_IDLE    = 2'd0,
        MON_SUSPECT = 2'd1,
        MON_ERR     = 2'd2
    } mon_state_t;

    // FIFO storage and pointers (one extra MSB distinguishes full from empty)
    logic [7:0]       r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    // Monitor FSM
    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    logic [RW-1:0]    r_run;
    logic [RW-1:0]    w_run_nxt;
    logic [RW-1:0]    w_run_inc;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_ee_cond;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = done_in && (!w_full || w_pop);
    assign w_drop  = done_in && w_full && !w_pop;

    assign m_valid  = !w_empty;
    assign m_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign full     = w_full;
    assign empty    = w_empty;
    assign acc_cnt  = r_acc_cnt;
    assign drop_cnt = r_drop_cnt;
    assign err_flag = (r_state == MON_ERR);

    // Write accepted bytes into storage; contents need no reset since the
    // pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_in;
        end
    end

    // Pointer and saturating counter updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_acc_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_acc_cnt != {CNT_W{1'b1}}) begin
                    r_acc_cnt <= r_acc_cnt + 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Monitor state and run-length register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MON_IDLE;
            r_run   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    assign w_ee_cond = (data_in == ERR_BYTE) && !done_in;
    assign w_run_inc = r_run + RW'(1);

    // Monitor next-state: count consecutive EE cycles, err_clr wins over all
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (err_clr) begin
            w_state_nxt = MON_IDLE;
            w_run_nxt   = '0;
        end else begin
            case (r_state)
                MON_IDLE: begin
                    if (w_ee_cond) begin
                        w_run_nxt   = RW'(1);
                        w_state_nxt = (ERR_CYCLES == 1) ? MON_ERR : MON_SUSPECT;
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                MON_SUSPECT: begin
                    if (w_ee_cond) begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc >= ERR_MAX) begin
                            w_state_nxt = MON_ERR;
                        end
                    end else begin
                        w_run_nxt   = '0;
                        w_state_nxt = MON_IDLE;
                    end
                end
                MON_ERR: begin
                    w_state_nxt = MON_ERR;
                end
                default: begin
                    w_state_nxt = MON_IDLE;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

endmodule
